// File: rtl/serial_link_obi_tx_fifo.sv
// Transmit FIFO for the serial link. The host pushes words over an OBI slave port.
// An AXI write master drains one single-beat write per entry to a programmable address.
module serial_link_obi_tx_fifo #(
  parameter int unsigned          Depth       = 8,
  parameter int unsigned          AddrWidth   = 32,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [AddrWidth-1:0] DestAddrRst = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 obi_req_i,
  output logic                 obi_gnt_o,
  input  logic [AddrWidth-1:0] obi_addr_i,
  input  logic                 obi_we_i,
  input  logic [3:0]           obi_be_i,
  input  logic [31:0]          obi_wdata_i,
  output logic                 obi_rvalid_o,
  output logic [31:0]          obi_rdata_o,
  output logic                 aw_valid_o,
  input  logic                 aw_ready_i,
  output logic [AddrWidth-1:0] aw_addr_o,
  output logic                 w_valid_o,
  input  logic                 w_ready_i,
  output logic [31:0]          w_data_o,
  output logic [3:0]           w_strb_o,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  input  logic [1:0]           b_resp_i,
  output logic                 fifo_empty_o,
  output logic                 fifo_full_o,
  output logic                 busy_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DEST   = 2'd2;
  localparam logic [1:0] REG_ERR    = 2'd3;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_B} state_e;

  state_e                 state_reg, state_next;
  logic                   aw_done_reg, aw_done_next;
  logic                   w_done_reg, w_done_next;
  logic [AddrWidth-1:0]   aw_addr_reg, aw_addr_next;
  logic [31:0]            w_data_reg;
  logic [3:0]             w_strb_reg;

  logic [35:0]            mem [Depth];
  logic [PtrW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CntW-1:0]        count_reg;
  logic [AddrWidth-1:0]   dest_addr_reg;
  logic [7:0]             err_cnt_reg;
  logic                   rvalid_reg;
  logic [31:0]            rdata_reg;

  logic [1:0]             reg_sel;
  logic                   access, push, pop, load;
  logic [31:0]            rd_val;
  logic                   unused_addr_bits;

  assign reg_sel          = obi_addr_i[3:2];
  assign unused_addr_bits = ^{obi_addr_i[AddrWidth-1:4], obi_addr_i[1:0]};

  assign fifo_empty_o = (count_reg == '0);
  assign fifo_full_o  = (count_reg == CntW'(Depth));
  assign busy_o       = (state_reg != IDLE);

  // A DATA write into a full FIFO is the only access that is ever stalled.
  assign obi_gnt_o = !(obi_we_i && (reg_sel == REG_DATA) && fifo_full_o);
  assign access    = obi_req_i & obi_gnt_o;
  assign push      = access & obi_we_i & (reg_sel == REG_DATA);
  assign pop       = (state_reg == WAIT_B) & b_valid_i;
  assign load      = (state_reg == IDLE) & ~fifo_empty_o;

  // Storage and the head read have no reset; valids gate everything downstream.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg] <= {obi_wdata_i, obi_be_i};
    if (load) {w_data_reg, w_strb_reg} <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CntW'(1);
        2'b01:   count_reg <= count_reg - CntW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_STATUS: begin
        rd_val[0]    = fifo_empty_o;
        rd_val[1]    = fifo_full_o;
        rd_val[2]    = busy_o;
        rd_val[15:8] = 8'(count_reg);
      end
      REG_DEST: rd_val = 32'(dest_addr_reg);
      REG_ERR:  rd_val[7:0] = err_cnt_reg;
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dest_addr_reg <= DestAddrRst;
      err_cnt_reg   <= '0;
      rvalid_reg    <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      rvalid_reg <= access;
      rdata_reg  <= (access && !obi_we_i) ? rd_val : '0;
      if (access && obi_we_i && (reg_sel == REG_DEST))
        dest_addr_reg <= AddrWidth'(obi_wdata_i);
      // A software clear takes priority over a simultaneous error response.
      if (access && obi_we_i && (reg_sel == REG_ERR))
        err_cnt_reg <= '0;
      else if (pop && (b_resp_i != 2'b00) && (err_cnt_reg != 8'hFF))
        err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign obi_rvalid_o = rvalid_reg;
  assign obi_rdata_o  = rdata_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      aw_addr_reg <= DestAddrRst;
    end else begin
      state_reg   <= state_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      aw_addr_reg <= aw_addr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    aw_addr_next = aw_addr_reg;
    aw_valid_o   = 1'b0;
    w_valid_o    = 1'b0;
    b_ready_o    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty_o) begin
          state_next   = SEND;
          aw_addr_next = dest_addr_reg;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
        end
      end
      SEND: begin
        aw_valid_o = !aw_done_reg;
        w_valid_o  = !w_done_reg;
        if (aw_valid_o && aw_ready_i) aw_done_next = 1'b1;
        if (w_valid_o && w_ready_i)   w_done_next  = 1'b1;
        if ((aw_done_reg || aw_ready_i) && (w_done_reg || w_ready_i))
          state_next = WAIT_B;
      end
      WAIT_B: begin
        b_ready_o = 1'b1;
        if (b_valid_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign aw_addr_o = aw_addr_reg;
  assign w_data_o  = w_data_reg;
  assign w_strb_o  = w_strb_reg;

endmodule

// File: tb/tb_serial_link_obi_tx_fifo.sv
// Directed bench for the OBI-to-AXI transmit FIFO: register table plus
// hand-written sequences for fill, channel skew, errors, DEST change and reset.
module tb_serial_link_obi_tx_fifo;

  localparam logic [1:0] R_DATA = 2'd0, R_STATUS = 2'd1, R_DEST = 2'd2, R_ERR = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        obi_req, obi_gnt, obi_we, obi_rvalid;
  logic [31:0] obi_addr, obi_wdata, obi_rdata;
  logic [3:0]  obi_be;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [31:0] aw_addr, w_data;
  logic [3:0]  w_strb;
  logic [1:0]  b_resp;
  logic        fifo_empty, fifo_full, busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] aw_q[$];
  logic [35:0] w_q[$];

  always #5 clk = ~clk;

  serial_link_obi_tx_fifo dut (
    .clk_i(clk), .rst_ni(rst_n),
    .obi_req_i(obi_req), .obi_gnt_o(obi_gnt), .obi_addr_i(obi_addr), .obi_we_i(obi_we),
    .obi_be_i(obi_be), .obi_wdata_i(obi_wdata), .obi_rvalid_o(obi_rvalid), .obi_rdata_o(obi_rdata),
    .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr),
    .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data), .w_strb_o(w_strb),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_resp_i(b_resp),
    .fifo_empty_o(fifo_empty), .fifo_full_o(fifo_full), .busy_o(busy)
  );

  // Inputs change just after posedge, so the negedge view equals the edge view.
  always @(negedge clk) begin
    if (rst_n && aw_valid && aw_ready) aw_q.push_back(aw_addr);
    if (rst_n && w_valid && w_ready)   w_q.push_back({w_strb, w_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else
      $display("ok   %s: 0x%08h", name, act);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic obi_access(input logic [1:0] sel, input logic we, input logic [31:0] wdata,
                            output logic [31:0] rdata);
    int waited = 0;
    obi_req = 1'b1; obi_addr = {28'd0, sel, 2'b00}; obi_we = we; obi_wdata = wdata; obi_be = 4'hF;
    #0;
    while (!obi_gnt && waited < 200) begin cyc(1); waited++; end
    if (!obi_gnt) begin
      n_checks++; n_fail++;
      $display("FAIL obi_gnt_timeout: got 0 expected 1 within 200 cycles");
      obi_req = 1'b0; obi_we = 1'b0; rdata = '0;
      return;
    end
    cyc(1);
    obi_req = 1'b0; obi_we = 1'b0;
    n_checks++;
    if (obi_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL obi_rvalid: got %b expected 1 one cycle after grant", obi_rvalid);
    end
    rdata = obi_rdata;
  endtask

  task automatic wait_empty(input string name, input int max);
    int w = 0;
    while (!(fifo_empty && !busy) && w < max) begin cyc(1); w++; end
    check({name, "_drained"}, {31'd0, fifo_empty && !busy}, 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] rd;
  int          base_aw, base_w;

  initial begin
    vecs[0]  = '{"wr_dest",      R_DEST,   1'b1, 32'h2000_0000, 32'h0};
    vecs[1]  = '{"rd_dest",      R_DEST,   1'b0, 32'h0,         32'h2000_0000};
    vecs[2]  = '{"rd_status",    R_STATUS, 1'b0, 32'h0,         32'h0000_0001};
    vecs[3]  = '{"rd_err",       R_ERR,    1'b0, 32'h0,         32'h0};
    vecs[4]  = '{"rd_data",      R_DATA,   1'b0, 32'h0,         32'h0};
    vecs[5]  = '{"wr_err",       R_ERR,    1'b1, 32'h5,         32'h0};
    vecs[6]  = '{"rd_err2",      R_ERR,    1'b0, 32'h0,         32'h0};
    vecs[7]  = '{"wr_status_ro", R_STATUS, 1'b1, 32'hFF,        32'h0};
    vecs[8]  = '{"rd_status2",   R_STATUS, 1'b0, 32'h0,         32'h0000_0001};
    vecs[9]  = '{"wr_dest2",     R_DEST,   1'b1, 32'h1234_5678, 32'h0};
    vecs[10] = '{"rd_dest2",     R_DEST,   1'b0, 32'h0,         32'h1234_5678};
    vecs[11] = '{"wr_dest3",     R_DEST,   1'b1, 32'h2000_0000, 32'h0};

    rst_n = 1'b0; obi_req = 0; obi_addr = 0; obi_we = 0; obi_be = 0; obi_wdata = 0;
    aw_ready = 1; w_ready = 1; b_valid = 1; b_resp = 2'b00;
    #23;
    check("rst_gnt",      {31'd0, obi_gnt},    32'd1);
    check("rst_rvalid",   {31'd0, obi_rvalid}, 32'd0);
    check("rst_rdata",    obi_rdata,           32'd0);
    check("rst_aw_valid", {31'd0, aw_valid},   32'd0);
    check("rst_w_valid",  {31'd0, w_valid},    32'd0);
    check("rst_b_ready",  {31'd0, b_ready},    32'd0);
    check("rst_flags",    {29'd0, busy, fifo_full, fifo_empty}, 32'b001);
    @(posedge clk); #1; rst_n = 1'b1;
    cyc(2);

    for (int i = 0; i < 12; i++) begin
      obi_access(vecs[i].sel, vecs[i].we, vecs[i].wdata, rd);
      check(vecs[i].name, rd, vecs[i].exp);
    end

    // Single push with every AXI channel ready immediately
    base_aw = aw_q.size(); base_w = w_q.size();
    obi_access(R_DATA, 1'b1, 32'hDEAD_BEEF, rd);
    check("push_rdata", rd, 32'h0);
    wait_empty("single", 50);
    check("single_aw_cnt", aw_q.size() - base_aw, 32'd1);
    check("single_w_cnt",  w_q.size() - base_w,   32'd1);
    if (aw_q.size() > base_aw) check("single_aw_addr", aw_q[base_aw], 32'h2000_0000);
    if (w_q.size() > base_w) begin
      check("single_w_data", w_q[base_w][31:0], 32'hDEAD_BEEF);
      check("single_w_strb", {28'd0, w_q[base_w][35:32]}, 32'hF);
    end

    // Fill to full while AW is stalled
    base_w = w_q.size();
    aw_ready = 1'b0;
    for (int i = 0; i < 8; i++) obi_access(R_DATA, 1'b1, 32'(i), rd);
    check("fill_full", {31'd0, fifo_full}, 32'd1);
    obi_access(R_STATUS, 1'b0, 32'h0, rd);
    check("fill_status", rd, 32'h0000_0806);
    obi_req = 1'b1; obi_addr = 32'h0; obi_we = 1'b1; obi_wdata = 32'd8; obi_be = 4'hF;
    #1;
    check("full_gnt_low0", {31'd0, obi_gnt}, 32'd0);
    cyc(3);
    check("full_gnt_low3", {31'd0, obi_gnt}, 32'd0);
    aw_ready = 1'b1;
    begin
      int w = 0;
      while (!obi_gnt && w < 20) begin cyc(1); w++; end
    end
    check("full_gnt_after_b", {31'd0, obi_gnt}, 32'd1);
    cyc(1);
    obi_req = 1'b0; obi_we = 1'b0;
    check("full_push_rvalid", {31'd0, obi_rvalid}, 32'd1);
    wait_empty("fill", 200);
    check("fill_w_cnt", w_q.size() - base_w, 32'd9);
    for (int i = 0; i < 9; i++)
      if (w_q.size() > base_w + i) check($sformatf("drain_%0d", i), w_q[base_w+i][31:0], 32'(i));

    // Channel skew: W ready three cycles ahead of AW ready
    aw_ready = 1'b0; w_ready = 1'b0;
    obi_access(R_DATA, 1'b1, 32'hA5A5_0001, rd);
    cyc(1);
    check("skew_both_valid", {30'd0, aw_valid, w_valid}, 32'b11);
    check("skew_b_ready0",   {31'd0, b_ready}, 32'd0);
    check("skew_w_data",     w_data, 32'hA5A5_0001);
    w_ready = 1'b1;
    cyc(1);
    w_ready = 1'b0;
    check("skew_w_dropped",  {30'd0, aw_valid, w_valid}, 32'b10);
    check("skew_b_ready1",   {31'd0, b_ready}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      cyc(1);
      check("skew_aw_hold",   {31'd0, aw_valid}, 32'd1);
      check("skew_aw_stable", aw_addr, 32'h2000_0000);
      check("skew_b_ready_k", {31'd0, b_ready}, 32'd0);
    end
    aw_ready = 1'b1;
    cyc(1);
    check("skew_aw_dropped", {31'd0, aw_valid}, 32'd0);
    check("skew_b_ready",    {31'd0, b_ready}, 32'd1);
    w_ready = 1'b1;
    wait_empty("skew", 50);

    // Error responses: counted, still popped, saturating
    b_resp = 2'b10;
    for (int i = 0; i < 3; i++) obi_access(R_DATA, 1'b1, 32'h100 + 32'(i), rd);
    wait_empty("err3", 50);
    obi_access(R_ERR, 1'b0, 32'h0, rd);
    check("err_cnt_3", rd, 32'd3);
    for (int i = 0; i < 300; i++) obi_access(R_DATA, 1'b1, 32'(i), rd);
    wait_empty("err300", 100);
    obi_access(R_ERR, 1'b0, 32'h0, rd);
    check("err_cnt_sat", rd, 32'd255);

    // ERR clear in the same cycle as an error response
    aw_ready = 1'b0; b_valid = 1'b0;
    obi_access(R_DATA, 1'b1, 32'h77, rd);
    cyc(1);
    aw_ready = 1'b1;
    cyc(1);
    check("clr_wait_b", {31'd0, b_ready}, 32'd1);
    b_valid = 1'b1; obi_req = 1'b1; obi_addr = {28'd0, R_ERR, 2'b00}; obi_we = 1'b1; obi_wdata = 0;
    cyc(1);
    obi_req = 1'b0; obi_we = 1'b0;
    obi_access(R_ERR, 1'b0, 32'h0, rd);
    check("err_clear_wins", rd, 32'd0);
    check("clr_popped", {31'd0, fifo_empty}, 32'd1);
    b_resp = 2'b00;

    // DEST changed while an entry waits for its B response
    base_aw = aw_q.size();
    b_valid = 1'b0;
    obi_access(R_DATA, 1'b1, 32'h11, rd);
    obi_access(R_DATA, 1'b1, 32'h22, rd);
    begin
      int w = 0;
      while (!b_ready && w < 20) begin cyc(1); w++; end
    end
    check("dest_in_wait_b", {31'd0, b_ready}, 32'd1);
    obi_access(R_DEST, 1'b1, 32'h3000_0000, rd);
    b_valid = 1'b1;
    wait_empty("dest", 50);
    check("dest_aw_cnt", aw_q.size() - base_aw, 32'd2);
    if (aw_q.size() > base_aw + 1) begin
      check("dest_old_addr", aw_q[base_aw],   32'h2000_0000);
      check("dest_new_addr", aw_q[base_aw+1], 32'h3000_0000);
    end

    // Reset in the middle of SEND with entries queued
    aw_ready = 1'b0; w_ready = 1'b0;
    for (int i = 0; i < 4; i++) obi_access(R_DATA, 1'b1, 32'h40 + 32'(i), rd);
    check("rst_mid_aw_valid", {31'd0, aw_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valids", {29'd0, aw_valid, w_valid, busy}, 32'd0);
    cyc(2);
    rst_n = 1'b1; aw_ready = 1'b1; w_ready = 1'b1;
    cyc(1);
    check("rst_mid_empty", {31'd0, fifo_empty}, 32'd1);
    obi_access(R_STATUS, 1'b0, 32'h0, rd);
    check("rst_mid_status", rd, 32'h1);
    obi_access(R_DEST, 1'b0, 32'h0, rd);
    check("rst_mid_dest", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_link_obi_tx_fifo.md
Name: serial_link_obi_tx_fifo

Overview:
- Transmit-side buffer for the x-heep serial link; the counterpart of the receive FIFO that the OBI reader port drains.
- The host CPU pushes 32-bit words through an OBI slave port into a FIFO.
- A write-only AXI master drains the FIFO toward the serial link's AXI input, issuing one single-beat write per entry to a programmable remote address.
- Also exposes status, destination-address and error-count registers.

Parameters:
- Depth, 8, FIFO entries; power of 2, at least 2.
- AddrWidth, 32, OBI and AXI address width.
- DataWidth, 32, data width; fixed at 32.
- DestAddrRst, 32'h0, reset value of the destination-address register.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- obi_req_i  in  1  OBI request.
- obi_gnt_o  out  1  OBI grant.
- obi_addr_i  in  AddrWidth  OBI address; bits [3:2] decoded.
- obi_we_i  in  1  OBI write enable.
- obi_be_i  in  4  OBI byte enables.
- obi_wdata_i  in  32  OBI write data.
- obi_rvalid_o  out  1  OBI response valid.
- obi_rdata_o  out  32  OBI read data.
- aw_valid_o  out  1  AXI AW valid.
- aw_ready_i  in  1  AXI AW ready.
- aw_addr_o  out  AddrWidth  AXI AW address.
- w_valid_o  out  1  AXI W valid.
- w_ready_i  in  1  AXI W ready.
- w_data_o  out  32  AXI W data.
- w_strb_o  out  4  AXI W strobe.
- b_valid_i  in  1  AXI B valid.
- b_ready_o  out  1  AXI B ready.
- b_resp_i  in  2  AXI B response.
- fifo_empty_o  out  1  FIFO empty.
- fifo_full_o  out  1  FIFO full.
- busy_o  out  1  AXI transaction in flight.

Behaviour:
- Clocking and reset: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset values:
  - FIFO empty, count 0, pointers 0.
  - FSM in IDLE; dest_addr = DestAddrRst; err_cnt = 0.
  - Outputs: obi_gnt_o=1 (FIFO not full); obi_rvalid_o=0; obi_rdata_o=0; aw_valid_o=0; w_valid_o=0; b_ready_o=0; fifo_empty_o=1; fifo_full_o=0; busy_o=0.
- Register map, decoded on obi_addr_i[3:2]:
  - 0 DATA: write pushes {wdata, be}; read returns 0.
  - 1 STATUS, read-only: [0] empty, [1] full, [2] busy, [15:8] count.
  - 2 DEST: read/write destination address.
  - 3 ERR: read returns the 8-bit err_cnt; any write clears it to 0.
- OBI handshake:
  - obi_gnt_o is combinational.
  - obi_gnt_o = 1 for all accesses except a DATA write while full, where it is 0.
  - Every granted access produces obi_rvalid_o=1 exactly one cycle later; rdata is registered with the access.
  - Writes return rdata=0.
  - No access is ever dropped; an ungranted request must be held by the master.
- FIFO:
  - Push occurs on granted DATA write.
  - Pop occurs only on the B handshake (b_valid_i & b_ready_o); the head stays valid until its write is acknowledged.
  - Push while full is never granted, even when a pop happens in the same cycle.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo Depth; count width is clog2(Depth)+1.
  - fifo_empty_o and fifo_full_o are registered-state derived, combinational from count.
- AXI FSM:
  - IDLE: if the FIFO is not empty, go to SEND; latch aw_addr_o=dest_addr and w_data_o/w_strb_o=head.
  - SEND:
    - aw_valid_o and w_valid_o are both asserted in the first SEND cycle.
    - Each channel deasserts independently after its handshake; aw_done/w_done flags record completion.
    - When both are done (same or different cycles), go to WAIT_B.
    - valid, once asserted, never drops before ready, and addr/data stay stable.
  - WAIT_B:
    - b_ready_o=1.
    - On b_valid_i: pop; if b_resp_i != 2'b00, err_cnt increments, saturating at 255; go to IDLE.
  - busy_o = state != IDLE.
  - Minimum entry period is 3 cycles: IDLE→SEND→WAIT_B with ready and B both immediate, back-to-back entries.
- DEST written mid-transaction: the current transaction keeps its latched address; the new value applies from the next entry.
- ERR clear in the same cycle as an error increment: the clear wins, and err_cnt = 0.
- Reset asserted mid-transaction: everything returns immediately to reset values; pending FIFO contents are lost; no AXI valid is held.

Test Plan:
- Single push: OBI write 0xDEADBEEF, be=0xF, to DATA with DEST=0x2000_0000, AW/W/B ready immediately → aw_addr_o=0x2000_0000, w_data_o=0xDEADBEEF, w_strb_o=0xF; fifo_empty_o returns to 1 after the B handshake; rvalid one cycle after gnt.
- Fill to full: aw_ready_i=0; push 8 words, 0..7 → fifo_full_o=1 and STATUS count=8; a 9th DATA write sees gnt=0 until aw_ready_i=1 and the first B completes; drain order on W is 0..7.
- Channel skew: w_ready_i rises 3 cycles before aw_ready_i → w_valid_o drops after its handshake, aw_valid_o holds with a stable address, and b_ready_o asserts only after both handshakes.
- Error counting: return b_resp_i=2'b10 for 3 entries → ERR reads 3 and the entries are still popped; 300 errors → ERR reads 255; writing ERR while an error arrives → ERR reads 0.
- DEST change mid-flight: write DEST=0x3000_0000 while in WAIT_B with entries queued → the in-flight entry keeps its old address and the next AW uses 0x3000_0000.
- Reset mid-SEND: assert rst_ni low with 4 entries queued and aw_valid_o=1 → aw_valid_o, w_valid_o and busy_o are 0 immediately; after release fifo_empty_o=1, STATUS=0x1, DEST=DestAddrRst.
